// File: rtl/lc3b_types.sv
// Shared types and constants for the 128-bit line memory interface.
package lc3b_types;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } resp_state_e;

  localparam int LINE_OFFSET_BITS = 4;

endpackage

// File: rtl/line_array.sv
// Single-port synchronous line RAM: write-enable, registered read, no reset.
module line_array
  import lc3b_types::*;
#(
  parameter int INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] idx,
  input  logic [127:0]          wdata,
  output logic [127:0]          rdata
);

  lc3b_line mem [2**INDEX_BITS];
  lc3b_line rdata_q;

  // Write the addressed line, or capture it into the read register; the read register holds otherwise.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end else if (re) begin
      rdata_q <= mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Responder for the 128-bit line memory interface: latches one request, waits a
// programmable latency, then completes with a one-cycle resp pulse.
module line_mem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         read,
  input  logic         write,
  input  logic [15:0]  address,
  input  logic [127:0] wdata,
  output logic         resp,
  output logic [127:0] rdata,
  output logic         proto_err
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  resp_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  op_write_q, op_write_d;
  logic [15:0]           addr_q, addr_d;
  lc3b_line              wdata_q, wdata_d;
  logic                  perr_q, perr_d;
  logic                  resp_q, resp_d;
  logic                  rd_seen_q, rd_seen_d;

  logic                  ram_we_s;
  logic                  ram_re_s;
  logic [INDEX_BITS-1:0] ram_idx_s;
  lc3b_line              ram_wdata_s;
  lc3b_line              ram_rdata_s;
  logic                  req_live_s;

  // Next-state, latch, protocol-check and RAM-port logic for the request FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_write_d  = op_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    perr_d      = perr_q;
    resp_d      = 1'b0;
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_idx_s   = addr_q[INDEX_BITS+3:LINE_OFFSET_BITS];
    ram_wdata_s = wdata_q;
    req_live_s  = op_write_q ? write : read;

    case (state_q)
      ST_IDLE: begin
        if (read || write) begin
          // A simultaneous read+write is treated as a write and flagged.
          op_write_d = write;
          addr_d     = address;
          wdata_d    = wdata;
          cnt_d      = CNT_LOAD;
          if (read && write) begin
            perr_d = 1'b1;
          end else begin
            perr_d = perr_q;
          end
          if (LATENCY == 1) begin
            // No wait cycles: the RAM is accessed with the live request this edge.
            state_d     = ST_DONE;
            resp_d      = 1'b1;
            ram_idx_s   = address[INDEX_BITS+3:LINE_OFFSET_BITS];
            ram_wdata_s = wdata;
            ram_we_s    = write;
            ram_re_s    = ~write;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // The requester must hold its request and operands stable while waiting.
        if (!req_live_s || (address != addr_q) || (op_write_q && (wdata != wdata_q))) begin
          perr_d = 1'b1;
        end else begin
          perr_d = perr_q;
        end
        // Leave WAIT on the edge where the counter reaches zero.
        if (cnt_q == 4'd1) begin
          state_d  = ST_DONE;
          resp_d   = 1'b1;
          ram_we_s = op_write_q;
          ram_re_s = ~op_write_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_seen_d = rd_seen_q | ram_re_s;
  end

  // State, counter, latched request and output flags; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      op_write_q <= 1'b0;
      addr_q     <= 16'd0;
      wdata_q    <= 128'd0;
      perr_q     <= 1'b0;
      resp_q     <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      perr_q     <= perr_d;
      resp_q     <= resp_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  // RAM accesses are suppressed while reset is held so an aborted write never lands.
  line_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_line_array (
    .clk  (clk),
    .we   (ram_we_s & rst_n),
    .re   (ram_re_s & rst_n),
    .idx  (ram_idx_s),
    .wdata(ram_wdata_s),
    .rdata(ram_rdata_s)
  );

  assign resp      = resp_q;
  // The RAM read register has no reset, so rdata reads as zero until the first read completes.
  assign rdata     = rd_seen_q ? ram_rdata_s : 128'd0;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed self-checking bench for line_mem_responder (LATENCY=4 and LATENCY=1 instances).
module tb_line_mem_responder;

  logic         clk;
  logic         rst_n;
  logic         read_a, write_a, resp_a, perr_a;
  logic [15:0]  address_a;
  logic [127:0] wdata_a, rdata_a;
  logic         read_b, write_b, resp_b, perr_b;
  logic [15:0]  address_b;
  logic [127:0] wdata_b, rdata_b;

  int n_cmp;
  int n_err;

  localparam logic [127:0] L1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] LA = 128'hAAAA_0000_AAAA_1111_AAAA_2222_AAAA_3333;
  localparam logic [127:0] LB = 128'hBBBB_4444_BBBB_5555_BBBB_6666_BBBB_7777;
  localparam logic [127:0] LC = 128'hCCCC_8888_CCCC_9999_CCCC_AAAA_CCCC_BBBB;
  localparam logic [127:0] LD = 128'hDDDD_CCCC_DDDD_DDDD_DDDD_EEEE_DDDD_FFFF;
  localparam logic [127:0] LE = 128'hEEEE_1234_EEEE_5678_EEEE_9ABC_EEEE_DEF0;
  localparam logic [127:0] LF = 128'hF00D_F00D_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] LO = 128'h0A0A_0B0B_0C0C_0D0D_0E0E_0F0F_1010_2020;

  line_mem_responder #(.LATENCY(4), .INDEX_BITS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .read(read_a), .write(write_a), .address(address_a),
    .wdata(wdata_a), .resp(resp_a), .rdata(rdata_a), .proto_err(perr_a)
  );

  line_mem_responder #(.LATENCY(1), .INDEX_BITS(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .read(read_b), .write(write_b), .address(address_b),
    .wdata(wdata_b), .resp(resp_b), .rdata(rdata_b), .proto_err(perr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One LATENCY=4 transaction on dut_a: drive at a negedge, expect resp only after the 4th edge.
  task automatic txn_a(input string tag, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [127:0] data);
    @(negedge clk);
    read_a = rd; write_a = wr; address_a = addr; wdata_a = data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val({tag, "_resp_early"}, {127'd0, resp_a}, 128'd0);
    end
    @(negedge clk);
    check_val({tag, "_resp"}, {127'd0, resp_a}, 128'd1);
    read_a = 1'b0; write_a = 1'b0;
    @(negedge clk);
    check_val({tag, "_resp_end"}, {127'd0, resp_a}, 128'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    read_a = 1'b0; write_a = 1'b0; address_a = 16'd0; wdata_a = 128'd0;
    read_b = 1'b0; write_b = 1'b0; address_b = 16'd0; wdata_b = 128'd0;
    repeat (2) @(negedge clk);
    check_val("rst_resp_a", {127'd0, resp_a}, 128'd0);
    check_val("rst_rdata_a", rdata_a, 128'd0);
    check_val("rst_perr_a", {127'd0, perr_a}, 128'd0);
    check_val("rst_resp_b", {127'd0, resp_b}, 128'd0);
    check_val("rst_rdata_b", rdata_b, 128'd0);
    rst_n = 1'b1;

    // Basic write then read of the same line through an offset address.
    txn_a("t1_wr", 1'b0, 1'b1, 16'h0040, L1);
    check_val("t1_rdata_after_wr", rdata_a, 128'd0);
    txn_a("t1_rd", 1'b1, 1'b0, 16'h004F, 128'd0);
    check_val("t1_rdata", rdata_a, L1);

    // Aliasing: 0x1010 maps to the same line as 0x0010.
    txn_a("t3_wrA", 1'b0, 1'b1, 16'h0010, LA);
    txn_a("t3_wrB", 1'b0, 1'b1, 16'h1010, LB);
    check_val("t3_rdata_held", rdata_a, L1);
    txn_a("t3_rd", 1'b1, 1'b0, 16'h0010, 128'd0);
    check_val("t3_rdata", rdata_a, LB);
    check_val("t3_perr", {127'd0, perr_a}, 128'd0);

    // LATENCY=1 instance: resp in the cycle right after the sampling edge.
    @(negedge clk);
    write_b = 1'b1; address_b = 16'h0000; wdata_b = LF;
    @(negedge clk);
    check_val("t2_wr_resp", {127'd0, resp_b}, 128'd1);
    write_b = 1'b0;
    @(negedge clk);
    check_val("t2_wr_resp_end", {127'd0, resp_b}, 128'd0);
    read_b = 1'b1;
    @(negedge clk);
    check_val("t2_rd_resp", {127'd0, resp_b}, 128'd1);
    check_val("t2_rdata", rdata_b, LF);
    read_b = 1'b0;
    @(negedge clk);
    check_val("t2_rd_resp_end", {127'd0, resp_b}, 128'd0);
    check_val("t2_rdata_held", rdata_b, LF);
    check_val("t2_perr", {127'd0, perr_b}, 128'd0);

    // Read dropped during WAIT: flag set, completion still at the nominal cycle.
    txn_a("t5_wr", 1'b0, 1'b1, 16'h0050, LE);
    @(negedge clk);
    read_a = 1'b1; address_a = 16'h0050;
    @(negedge clk);
    check_val("t5_resp_k", {127'd0, resp_a}, 128'd0);
    read_a = 1'b0;
    @(negedge clk);
    check_val("t5_perr", {127'd0, perr_a}, 128'd1);
    check_val("t5_resp_k1", {127'd0, resp_a}, 128'd0);
    @(negedge clk);
    check_val("t5_resp_k2", {127'd0, resp_a}, 128'd0);
    @(negedge clk);
    check_val("t5_resp", {127'd0, resp_a}, 128'd1);
    check_val("t5_rdata", rdata_a, LE);
    @(negedge clk);
    check_val("t5_resp_end", {127'd0, resp_a}, 128'd0);

    // Reset clears the sticky flag and rdata.
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rst2_perr", {127'd0, perr_a}, 128'd0);
    check_val("rst2_rdata", rdata_a, 128'd0);
    rst_n = 1'b1;

    // Simultaneous read+write: write only, flag set and sticky, rdata untouched.
    txn_a("t4_rw", 1'b1, 1'b1, 16'h0020, LC);
    check_val("t4_perr", {127'd0, perr_a}, 128'd1);
    check_val("t4_rdata_unchanged", rdata_a, 128'd0);
    txn_a("t4_rd", 1'b1, 1'b0, 16'h0020, 128'd0);
    check_val("t4_rdata", rdata_a, LC);
    check_val("t4_perr_sticky", {127'd0, perr_a}, 128'd1);

    // Reset two cycles into a write aborts it: no resp, line keeps old contents.
    txn_a("t6_old", 1'b0, 1'b1, 16'h0030, LO);
    @(negedge clk);
    write_a = 1'b1; address_a = 16'h0030; wdata_a = LD;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; write_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("t6_no_resp", {127'd0, resp_a}, 128'd0);
      if (i == 1) rst_n = 1'b1;
    end
    txn_a("t6_rd", 1'b1, 1'b0, 16'h0030, 128'd0);
    check_val("t6_rdata", rdata_a, LO);
    check_val("t6_perr", {127'd0, perr_a}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
